mastermind_solver: RTL and testbench

MASTERMIND_SOLVER -- requirements
Module: mastermind_solver

---
 rtl/mastermind_pkg.sv | 22 ++
 rtl/mastermind_score.sv | 38 +++
 rtl/mastermind_solver.sv | 139 +++++++++++++
 tb/tb_mastermind_solver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mastermind_pkg.sv
// Shared constants, FSM state encoding and feedback record for the Mastermind solver.
package mastermind_pkg;

  localparam int NUM_PEGS    = 4;
  localparam int PEG_W       = 3;
  localparam int CODE_W      = 12;
  localparam int NUM_COLOURS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_OFFER  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  typedef struct packed {
    logic [2:0] red;
    logic [2:0] white;
  } fb_t;

endpackage

// File: rtl/mastermind_score.sv
// Combinational Mastermind scorer: red = exact position matches,
// white = colour matches summed over all colours minus red.
module mastermind_score
  import mastermind_pkg::*;
(
  input  logic [CODE_W-1:0] code_a,
  input  logic [CODE_W-1:0] code_b,
  output logic [2:0]        red,
  output logic [2:0]        white
);

  logic [2:0] cnt_a;
  logic [2:0] cnt_b;
  logic [2:0] common;

  always_comb begin
    red    = '0;
    common = '0;
    cnt_a  = '0;
    cnt_b  = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (code_a[p*PEG_W +: PEG_W] == code_b[p*PEG_W +: PEG_W]) red = red + 3'd1;
    end
    for (int c = 0; c < NUM_COLOURS; c++) begin
      cnt_a = '0;
      cnt_b = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
        if (code_a[p*PEG_W +: PEG_W] == PEG_W'(c)) cnt_a = cnt_a + 3'd1;
        if (code_b[p*PEG_W +: PEG_W] == PEG_W'(c)) cnt_b = cnt_b + 3'd1;
      end
      common = common + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
    end
  end

  // common always covers the red matches, so this never underflows.
  assign white = common - red;

endmodule

// File: rtl/mastermind_solver.sv
// Mastermind code breaker: offers the lowest code consistent with all feedback so far.
// Optional build macro MM_SOLVER_STATS_EN adds the search_cycles statistics output.
module mastermind_solver
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              guess_valid,
  output logic [CODE_W-1:0] guess_out,
  input  logic              fb_valid,
  input  logic [2:0]        fb_red,
  input  logic [2:0]        fb_white,
  output logic              solved,
  output logic              fail,
  output logic              busy,
  output logic [3:0]        guess_count
`ifdef MM_SOLVER_STATS_EN
  ,
  output logic [15:0]       search_cycles
`endif
);

  // Handshake: guess_valid/guess_out are held stable in OFFER until fb_valid is
  // sampled high on a rising edge; that single edge consumes the feedback.
  // fb_valid in any other state is ignored.

  state_t            state;
  logic [CODE_W-1:0] cand;
  logic [3:0]        idx;

  logic [CODE_W-1:0] hist_guess [16];
  fb_t               hist_fb    [16];

  logic [2:0]  s_red;
  logic [2:0]  s_white;
  fb_t         score_fb;
  logic        fb_illegal;
  logic        fb_win;
  logic        fb_accept;
  logic [3:0]  gc_inc;

  mastermind_score u_score (
    .code_a (cand),
    .code_b (hist_guess[idx]),
    .red    (s_red),
    .white  (s_white)
  );

  assign score_fb   = {s_red, s_white};
  assign fb_illegal = (({1'b0, fb_red} + {1'b0, fb_white}) > 4'd4) ||
                      ((fb_red == 3'd4) && (fb_white != 3'd0));
  assign fb_win     = (fb_red == 3'd4);
  assign fb_accept  = (state == ST_OFFER) && fb_valid;
  assign gc_inc     = guess_count + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cand        <= '0;
      idx         <= '0;
      guess_count <= '0;
      solved      <= 1'b0;
      fail        <= 1'b0;
    end else if (start) begin
      state       <= ST_SEARCH;
      cand        <= '0;
      idx         <= '0;
      guess_count <= '0;
      solved      <= 1'b0;
      fail        <= 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (idx == guess_count) begin
            state <= ST_OFFER;
          end else if (score_fb == hist_fb[idx]) begin
            idx <= idx + 4'd1;
          end else if (cand == '1) begin
            // Candidate space exhausted; never wrap back to 0.
            state <= ST_FAIL;
            fail  <= 1'b1;
          end else begin
            cand <= cand + 1'b1;
            idx  <= '0;
          end
        end
        ST_OFFER: begin
          if (fb_valid) begin
            if (fb_illegal) begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end else if (fb_win) begin
              guess_count <= gc_inc;
              solved      <= 1'b1;
              state       <= ST_DONE;
            end else begin
              guess_count <= gc_inc;
              cand        <= cand + 1'b1;
              idx         <= '0;
              if (gc_inc == 4'(MAX_GUESSES)) begin
                state <= ST_FAIL;
                fail  <= 1'b1;
              end else begin
                state <= ST_SEARCH;
              end
            end
          end
        end
        default: state <= state;
      endcase
    end
  end

  // History needs no reset: only entries below guess_count are ever read.
  always_ff @(posedge clk) begin
    if (!reset && !start && fb_accept && !fb_illegal && !fb_win) begin
      hist_guess[guess_count] <= cand;
      hist_fb[guess_count]    <= {fb_red, fb_white};
    end
  end

`ifdef MM_SOLVER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || start) begin
      search_cycles <= '0;
    end else if ((state == ST_SEARCH) && (search_cycles != 16'hFFFF)) begin
      search_cycles <= search_cycles + 16'd1;
    end
  end
`endif

  assign guess_valid = (state == ST_OFFER);
  assign guess_out   = cand;
  assign busy        = (state == ST_SEARCH) || (state == ST_OFFER);

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: directed corner cases plus closed-loop games
// against a reference scorer and "lowest consistent code" solver model.
module tb_mastermind_solver;

  localparam int MAX_G  = 8;
  localparam int BUDGET = 20000;

  logic        clk;
  logic        reset;
  logic        start;
  logic        guess_valid;
  logic [11:0] guess_out;
  logic        fb_valid;
  logic [2:0]  fb_red;
  logic [2:0]  fb_white;
  logic        solved;
  logic        fail;
  logic        busy;
  logic [3:0]  guess_count;
`ifdef MM_SOLVER_STATS_EN
  logic [15:0] search_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  logic [11:0] h_guess[$];
  logic [5:0]  h_fb[$];

  mastermind_solver #(.MAX_GUESSES(MAX_G)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .guess_valid (guess_valid),
    .guess_out   (guess_out),
    .fb_valid    (fb_valid),
    .fb_red      (fb_red),
    .fb_white    (fb_white),
    .solved      (solved),
    .fail        (fail),
    .busy        (busy),
    .guess_count (guess_count)
`ifdef MM_SOLVER_STATS_EN
    ,
    .search_cycles (search_cycles)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [5:0] ref_score(input logic [11:0] a, input logic [11:0] b);
    int ca[8];
    int cb[8];
    int r;
    int common;
    int da;
    int db;
    r = 0;
    common = 0;
    for (int c = 0; c < 8; c++) begin
      ca[c] = 0;
      cb[c] = 0;
    end
    for (int p = 0; p < 4; p++) begin
      da = (int'(a) / (8 ** p)) % 8;
      db = (int'(b) / (8 ** p)) % 8;
      if (da == db) r++;
      ca[da]++;
      cb[db]++;
    end
    for (int c = 0; c < 8; c++) common += (ca[c] < cb[c]) ? ca[c] : cb[c];
    return {3'(r), 3'(common - r)};
  endfunction

  function automatic int next_cand(input int from);
    logic ok;
    for (int c = from; c < 4096; c++) begin
      ok = 1'b1;
      for (int i = 0; i < h_guess.size(); i++) begin
        if (ref_score(12'(c), h_guess[i]) != h_fb[i]) ok = 1'b0;
      end
      if (ok) return c;
    end
    return -1;
  endfunction

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic give_fb(input logic [2:0] r, input logic [2:0] w);
    fb_valid = 1'b1;
    fb_red   = r;
    fb_white = w;
    tick();
    fb_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < BUDGET; k++) begin
      if (guess_valid || solved || fail) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_game(input logic [11:0] secret, input string tag);
    int nxt;
    int n;
    logic ok;
    logic [11:0] g;
    logic [5:0] fb;
    h_guess.delete();
    h_fb.delete();
    do_start();
    nxt = next_cand(0);
    n = 0;
    forever begin
      wait_ready(tag, ok);
      if (!ok) break;
      if (nxt < 0) begin
        check({tag, "_exhaust_fail"}, fail, 1);
        check({tag, "_exhaust_gv"}, guess_valid, 0);
        break;
      end
      exp_q.push_back(12'(nxt));
      check({tag, "_gv"}, guess_valid, 1);
      g = exp_q.pop_front();
      check({tag, "_guess"}, guess_out, g);
      fb = ref_score(g, secret);
      give_fb(fb[5:3], fb[2:0]);
      n++;
      if (fb[5:3] == 3'd4) begin
        check({tag, "_solved"}, solved, 1);
        check({tag, "_count"}, guess_count, n);
        break;
      end
      h_guess.push_back(g);
      h_fb.push_back(fb);
      if (n == MAX_G) begin
        check({tag, "_limit_fail"}, fail, 1);
        check({tag, "_limit_count"}, guess_count, n);
        break;
      end
      nxt = next_cand(int'(g) + 1);
    end
  endtask

  // stimulus
  initial begin
    logic ok;
    int gv_seen;
    logic [11:0] rs;
    reset = 1'b1;
    start = 1'b1;
    fb_valid = 1'b0;
    fb_red = '0;
    fb_white = '0;
    tick();
    tick();
    check("reset_over_start_busy", busy, 0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("rst_gv", guess_valid, 0);
    check("rst_guess_out", guess_out, 0);
    check("rst_solved", solved, 0);
    check("rst_fail", fail, 0);
    check("rst_busy", busy, 0);
    check("rst_count", guess_count, 0);

    // start latency
    do_start();
    check("start_1cyc_gv", guess_valid, 0);
    check("start_1cyc_busy", busy, 1);
    tick();
    check("start_2cyc_gv", guess_valid, 1);
    check("start_2cyc_guess", guess_out, 12'o0000);
    check("start_2cyc_count", guess_count, 0);
`ifdef MM_SOLVER_STATS_EN
    check("stats_first", search_cycles, 1);
`endif
    repeat (3) tick();
    check("offer_hold_gv", guess_valid, 1);
    check("offer_hold_guess", guess_out, 12'o0000);

    // (0,0) -> 1111, and fb_valid ignored while searching
    give_fb(3'd0, 3'd0);
    check("fb00_count", guess_count, 1);
    give_fb(3'd4, 3'd0);
    wait_ready("fb00", ok);
    check("fb00_next", guess_out, 12'o1111);
    check("fb00_gv", guess_valid, 1);
    check("search_fb_ignored_count", guess_count, 1);
    check("search_fb_ignored_solved", solved, 0);

    // (4,0) on first guess
    do_start();
    tick();
    give_fb(3'd4, 3'd0);
    check("win_solved", solved, 1);
    check("win_gv", guess_valid, 0);
    check("win_busy", busy, 0);
    check("win_count", guess_count, 1);
    check("win_guess_out", guess_out, 12'o0000);
    give_fb(3'd0, 3'd0);
    check("done_fb_ignored", guess_count, 1);

    // closed-loop games
    run_game(12'o7531, "g7531");
    check("g7531_solved", solved, 1);
    check("g7531_final_guess", guess_out, 12'o7531);
    check("g7531_count_le8", (guess_count <= 4'd8), 1);
    run_game(12'o7777, "g7777");
    run_game(12'o7776, "g7776");
    for (int t = 0; t < 2; t++) begin
      rs = 12'($urandom_range(0, 4095));
      run_game(rs, "grand");
    end

    // (3,1) to 0000 -> exhaustion
    do_start();
    tick();
    give_fb(3'd3, 3'd1);
    gv_seen = 0;
    for (int k = 0; k < BUDGET; k++) begin
      if (fail) break;
      if (guess_valid) gv_seen++;
      tick();
    end
    check("exh_fail", fail, 1);
    check("exh_gv_never", gv_seen, 0);
    check("exh_busy", busy, 0);
    check("exh_count", guess_count, 1);

    // illegal feedback
    do_start();
    tick();
    give_fb(3'd3, 3'd2);
    check("ill32_fail", fail, 1);
    check("ill32_gv", guess_valid, 0);
    check("ill32_count", guess_count, 0);
    do_start();
    check("restart_from_fail_clear", fail, 0);
    tick();
    give_fb(3'd4, 3'd1);
    check("ill41_fail", fail, 1);
    check("ill41_solved", solved, 0);

    // restart mid-SEARCH
    do_start();
    tick();
    give_fb(3'd0, 3'd0);
    do_start();
    check("midsearch_1cyc_gv", guess_valid, 0);
    check("midsearch_count", guess_count, 0);
    tick();
    check("midsearch_2cyc_gv", guess_valid, 1);
    check("midsearch_guess", guess_out, 12'o0000);
    check("midsearch_fail", fail, 0);

    // reset mid-OFFER abandons the game
    reset = 1'b1;
    tick();
    reset = 1'b0;
    gv_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (guess_valid || busy) gv_seen++;
      tick();
    end
    check("rst_offer_quiet", gv_seen, 0);
    check("rst_offer_count", guess_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
